// File: rtl/tune_pkg.sv
// Shared constants for the medium-wave tuning controller: band raster, NCO phase width,
// FSM state codes and small elaboration-time helpers.
package tune_pkg;

    localparam int unsigned PINC_W      = 40;
    localparam int unsigned CHAN_W      = 7;
    localparam int unsigned BAND_LO_KHZ = 531;
    localparam int unsigned BAND_HI_KHZ = 1602;
    localparam int unsigned RASTER_KHZ  = 9;
    localparam int unsigned N_CH_BAND   = (BAND_HI_KHZ - BAND_LO_KHZ) / RASTER_KHZ + 1;

    // 2^40 * 9000 / 100e6
    localparam logic [PINC_W-1:0] PINC_STEP_9K = 40'h005E5F30E;

    typedef logic [1:0] tune_state_t;
    localparam tune_state_t StIdle    = 2'd0;
    localparam tune_state_t StStep    = 2'd1;
    localparam tune_state_t StPublish = 2'd2;
    localparam tune_state_t StSettle  = 2'd3;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [PINC_W-1:0] pinc_span(input int unsigned n_steps,
                                                    input logic [PINC_W-1:0] step);
        return PINC_W'(n_steps) * step;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-count debouncer, press pulse and auto-repeat.
// `inhibit` (the other button's debounced level) suppresses requests and holds the repeat timer.
module btn_debounce
    import tune_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    input  logic inhibit,
    output logic level,
    output logic req
);

    localparam int unsigned DEB_W   = cnt_w(DEB_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = cnt_w(RPT_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_C = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PER_C   = RPT_W'(REPEAT_PERIOD);

    logic             sync1_q, sync2_q;
    logic             level_q, level_prev_q;
    logic             rpt_mode_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             active, rise, rpt_fire;

    always_comb begin
        active   = level_q & ~inhibit;
        rise     = active & ~level_prev_q;
        rpt_fire = active & ~rise &
                   (rpt_mode_q ? (rpt_cnt_q == RPT_PER_C) : (rpt_cnt_q == RPT_DELAY_C));
        req      = rise | rpt_fire;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            deb_cnt_q    <= '0;
            rpt_cnt_q    <= '0;
            rpt_mode_q   <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;

            if (sync2_q != level_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    level_q   <= sync2_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 1'b1;
                end
            end else begin
                deb_cnt_q <= '0;
            end

            // rpt_cnt_q counts cycles since the last request of this press
            if (!active) begin
                rpt_cnt_q  <= '0;
                rpt_mode_q <= 1'b0;
            end else if (rise || rpt_fire) begin
                rpt_cnt_q  <= RPT_W'(1);
                rpt_mode_q <= ~rise;
            end else begin
                rpt_cnt_q  <= rpt_cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/tune_ctrl.sv
// Button-driven channel stepper: keeps the channel index and its NCO phase increment in step
// using add/subtract only, publishes each new increment and mutes audio while the chain settles.
module tune_ctrl
    import tune_pkg::*;
#(
    parameter int unsigned        N_CH          = N_CH_BAND,
    parameter int unsigned        CH_RESET      = 45,
    parameter logic [PINC_W-1:0]  PINC_RESET    = 40'h2656ABDE3,
    parameter logic [PINC_W-1:0]  PINC_STEP     = PINC_STEP_9K,
    parameter int unsigned        DEB_CYCLES    = 1000000,
    parameter int unsigned        REPEAT_DELAY  = 50000000,
    parameter int unsigned        REPEAT_PERIOD = 10000000,
    parameter int unsigned        MUTE_CYCLES   = 2000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              btn_up,
    input  logic              btn_dn,
    output logic [PINC_W-1:0] phase_inc,
    output logic              pinc_valid,
    output logic [CHAN_W-1:0] chan,
    output logic              mute,
    output logic              busy
);

    localparam logic [PINC_W-1:0] PINC_WRAP = pinc_span(N_CH - 1, PINC_STEP);
    localparam logic [CHAN_W-1:0] CH_LAST   = CHAN_W'(N_CH - 1);
    localparam logic [CHAN_W-1:0] CH_RST    = CHAN_W'(CH_RESET);
    localparam int unsigned       MUTE_W    = cnt_w(MUTE_CYCLES);
    localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_CYCLES - 1);

    logic up_level, dn_level, up_req, dn_req;

    btn_debounce #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_deb_up (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (btn_up),
        .inhibit (dn_level),
        .level   (up_level),
        .req     (up_req)
    );

    btn_debounce #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_deb_dn (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (btn_dn),
        .inhibit (up_level),
        .level   (dn_level),
        .req     (dn_req)
    );

    tune_state_t       state_q, state_d;
    logic [PINC_W-1:0] phase_q, phase_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [MUTE_W-1:0] mute_cnt_q, mute_cnt_d;

    // The step arithmetic is latched on entry to StStep, so phase_inc is already new during
    // StStep and pinc_valid follows one cycle later in StPublish.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        chan_d     = chan_q;
        mute_cnt_d = mute_cnt_q;
        case (state_q)
            StIdle: begin
                if (up_req) begin
                    state_d = StStep;
                    if (chan_q == CH_LAST) begin
                        chan_d  = '0;
                        phase_d = phase_q - PINC_WRAP;
                    end else begin
                        chan_d  = chan_q + 1'b1;
                        phase_d = phase_q + PINC_STEP;
                    end
                end else if (dn_req) begin
                    state_d = StStep;
                    if (chan_q == '0) begin
                        chan_d  = CH_LAST;
                        phase_d = phase_q + PINC_WRAP;
                    end else begin
                        chan_d  = chan_q - 1'b1;
                        phase_d = phase_q - PINC_STEP;
                    end
                end
            end
            StStep: state_d = StPublish;
            StPublish: begin
                state_d    = StSettle;
                mute_cnt_d = MUTE_LOAD;
            end
            StSettle: begin
                if (mute_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    mute_cnt_d = mute_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            phase_q    <= PINC_RESET;
            chan_q     <= CH_RST;
            mute_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            chan_q     <= chan_d;
            mute_cnt_q <= mute_cnt_d;
        end
    end

    always_comb begin
        phase_inc  = phase_q;
        chan       = chan_q;
        pinc_valid = (state_q == StPublish);
        mute       = (state_q == StPublish) || (state_q == StSettle);
        busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_tune_ctrl.sv
// Bench for tune_ctrl: directed scenarios plus random button activity, checked every cycle
// against an event-level model of debounce, repeat timing and the channel/increment relation.
module tb_tune_ctrl;

    localparam int N_CH   = 120;
    localparam int CH_RST = 45;
    localparam int DEB    = 4;
    localparam int RDELAY = 20;
    localparam int RPER   = 8;
    localparam int MUTE   = 10;
    localparam logic [39:0] PINC_RESET = 40'h2656ABDE3;
    localparam logic [39:0] PINC_STEP  = 40'h005E5F30E;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic [39:0] phase_inc;
    logic        pinc_valid;
    logic [6:0]  chan;
    logic        mute;
    logic        busy;

    always #5 CLK = ~CLK;

    tune_ctrl #(
        .N_CH          (N_CH),
        .CH_RESET      (CH_RST),
        .PINC_RESET    (PINC_RESET),
        .PINC_STEP     (PINC_STEP),
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RDELAY),
        .REPEAT_PERIOD (RPER),
        .MUTE_CYCLES   (MUTE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .phase_inc  (phase_inc),
        .pinc_valid (pinc_valid),
        .chan       (chan),
        .mute       (mute),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pv_seen  = 0;
    int mute_seen = 0;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state; index 0 = up, 1 = down
    bit          m_p1 [2];
    bit          m_p2 [2];
    bit          m_lvl [2];
    bit          m_prev [2];
    int          m_run [2];
    int          m_hold [2];
    int          m_tstep;
    int          m_chan;
    logic [39:0] m_pinc;

    function automatic logic [39:0] pinc_of(input int ch);
        longint d;
        d = longint'(ch) - longint'(CH_RST);
        return 40'(longint'(PINC_RESET) + d * longint'(PINC_STEP));
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_p1[b] = 0; m_p2[b] = 0; m_lvl[b] = 0; m_prev[b] = 0;
            m_run[b] = 0; m_hold[b] = 0;
        end
        m_tstep = 0;
        m_chan  = CH_RST;
        m_pinc  = PINC_RESET;
    endtask

    task automatic model_edge(input bit up, input bit dn, input bit rst);
        bit req [2];
        bit old_lvl [2];
        bit raw [2];
        int h;
        if (rst) begin
            model_reset();
            return;
        end
        raw[0] = up;
        raw[1] = dn;
        // Press at hold 0, then at RDELAY, then every RPER, only while the other is released
        for (int b = 0; b < 2; b++) begin
            h = m_hold[b];
            req[b] = m_lvl[b] && !m_lvl[1-b] &&
                     ((!m_prev[b] && h == 0) || h == RDELAY ||
                      (h > RDELAY && ((h - RDELAY) % RPER) == 0));
        end
        if (m_tstep == 0) begin
            if (req[0]) begin
                m_chan  = (m_chan + 1) % N_CH;
                m_pinc  = pinc_of(m_chan);
                m_tstep = 1;
            end else if (req[1]) begin
                m_chan  = (m_chan + N_CH - 1) % N_CH;
                m_pinc  = pinc_of(m_chan);
                m_tstep = 1;
            end
        end else begin
            m_tstep++;
            if (m_tstep == MUTE + 3) m_tstep = 0;
        end
        for (int b = 0; b < 2; b++) begin
            old_lvl[b] = m_lvl[b];
            if (m_p2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = m_p2[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_p2[b]   = m_p1[b];
            m_p1[b]   = raw[b];
            m_prev[b] = old_lvl[b];
        end
        for (int b = 0; b < 2; b++) begin
            if (m_lvl[b] && !m_lvl[1-b])
                m_hold[b] = (old_lvl[b] && !old_lvl[1-b]) ? m_hold[b] + 1 : 0;
            else
                m_hold[b] = 0;
        end
    endtask

    task automatic tick(input bit up, input bit dn, input bit rst);
        @(negedge CLK);
        btn_up = up;
        btn_dn = dn;
        RST    = rst;
        @(posedge CLK);
        model_edge(up, dn, rst);
        #1;
        check_eq("chan", 40'(chan), 40'(m_chan));
        check_eq("phase_inc", phase_inc, m_pinc);
        check_eq("pinc_valid", 40'(pinc_valid), 40'(m_tstep == 2));
        check_eq("mute", 40'(mute), 40'(m_tstep >= 2));
        check_eq("busy", 40'(busy), 40'(m_tstep != 0));
        if (pinc_valid === 1'b1) pv_seen++;
        if (mute === 1'b1) mute_seen++;
    endtask

    initial begin
        bit ru, rd, rr;
        int dur;
        model_reset();

        repeat (3) tick(0, 0, 1);
        check_eq("rst_chan", 40'(chan), 40'd45);
        check_eq("rst_phase", phase_inc, 40'h2656ABDE3);
        check_eq("rst_mute", 40'(mute), 40'd0);
        check_eq("rst_pinc_valid", 40'(pinc_valid), 40'd0);
        check_eq("rst_busy", 40'(busy), 40'd0);

        // Single press
        pv_seen = 0; mute_seen = 0;
        repeat (6) tick(1, 0, 0);
        repeat (30) tick(0, 0, 0);
        check_eq("press_chan", 40'(chan), 40'd46);
        check_eq("press_phase", phase_inc, 40'h26B50B0F1);
        check_eq("press_pv_count", 40'(pv_seen), 40'd1);
        check_eq("press_mute_len", 40'(mute_seen), 40'd11);

        // Bouncing down button never settles
        pv_seen = 0; mute_seen = 0;
        for (int i = 0; i < 40; i++) tick(0, ((i / 2) % 2) == 0, 0);
        repeat (10) tick(0, 0, 0);
        check_eq("bounce_chan", 40'(chan), 40'd46);
        check_eq("bounce_pv", 40'(pv_seen), 40'd0);
        check_eq("bounce_mute", 40'(mute_seen), 40'd0);

        // Hold down through the bottom of the band
        for (int i = 0; i < 2000 && m_chan != N_CH - 1; i++) tick(0, 1, 0);
        check_eq("wrap_dn_chan", 40'(chan), 40'd119);
        check_eq("wrap_dn_phase", phase_inc, 40'(PINC_RESET + 40'd74 * PINC_STEP));
        repeat (40) tick(0, 0, 0);
        repeat (6) tick(1, 0, 0);
        repeat (30) tick(0, 0, 0);
        check_eq("wrap_up_chan", 40'(chan), 40'd0);
        check_eq("wrap_up_phase", phase_inc, 40'(PINC_RESET - 40'd45 * PINC_STEP));
        repeat (6) tick(0, 1, 0);
        repeat (30) tick(0, 0, 0);
        check_eq("unwrap_chan", 40'(chan), 40'd119);
        check_eq("unwrap_phase", phase_inc, 40'(PINC_RESET + 40'd74 * PINC_STEP));

        // Auto-repeat: steps at +0, +20, +36, +52 (others dropped while busy)
        pv_seen = 0;
        repeat (66) tick(1, 0, 0);
        repeat (30) tick(0, 0, 0);
        check_eq("repeat_pv_count", 40'(pv_seen), 40'd4);
        check_eq("repeat_chan", 40'(chan), 40'd3);

        // Second button while the first is held, then both together
        repeat (12) tick(1, 0, 0);
        pv_seen = 0;
        repeat (15) tick(1, 1, 0);
        repeat (30) tick(0, 0, 0);
        check_eq("held_plus_dn_pv", 40'(pv_seen), 40'd0);
        pv_seen = 0;
        repeat (15) tick(1, 1, 0);
        repeat (30) tick(0, 0, 0);
        check_eq("both_pv", 40'(pv_seen), 40'd0);

        // Reset in the middle of the mute window
        repeat (6) tick(1, 0, 0);
        for (int i = 0; i < 50 && m_tstep != 5; i++) tick(0, 0, 0);
        check_eq("pre_rst_mute", 40'(mute), 40'd1);
        tick(0, 0, 1);
        check_eq("mid_rst_mute", 40'(mute), 40'd0);
        check_eq("mid_rst_busy", 40'(busy), 40'd0);
        check_eq("mid_rst_chan", 40'(chan), 40'd45);
        check_eq("mid_rst_phase", phase_inc, 40'h2656ABDE3);
        repeat (5) tick(0, 0, 0);

        // Random segments with bounce and occasional reset
        for (int s = 0; s < 300; s++) begin
            ru  = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 3) == 0);
            dur = $urandom_range(1, 40);
            for (int d = 0; d < dur; d++) begin
                rr = ($urandom_range(0, 299) == 0);
                tick(ru ^ ($urandom_range(0, 9) == 0), rd ^ ($urandom_range(0, 9) == 0), rr);
            end
        end
        repeat (40) tick(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tune_ctrl.md
Name: tune_ctrl

Overview:
- Button-driven tuning controller for the 1-bit AM receiver.
- Tracks a medium-wave channel index on a 9 kHz raster and keeps the matching NCO phase increment. The increment is updated by add/subtract only; no run-time multiplier.
- Sequences each retune as: debounce, step, publish the new increment, mute audio while the CIC/demod pipeline settles.
- Sits between the board buttons and the nco phase_inc input / audio mute, in the 100 MHz domain.

Parameters:
- N_CH, 120, number of channels (531-1602 kHz at 9 kHz spacing).
- CH_RESET, 45, channel index after reset (936 kHz).
- PINC_RESET, 40'h2656ABDE3, phase increment for CH_RESET at CLK = 100 MHz.
- PINC_STEP, 40'h005E5F30E, phase increment per 9 kHz step (2^40 * 9000 / 1e8).
- DEB_CYCLES, 1000000, cycles an input must stay stable to be accepted (10 ms).
- REPEAT_DELAY, 50000000, held cycles before auto-repeat starts.
- REPEAT_PERIOD, 10000000, cycles between auto-repeat steps.
- MUTE_CYCLES, 2000000, audio mute duration after each retune.

Ports:
- CLK  in  1  100 MHz system clock.
- RST  in  1  synchronous, active-high reset.
- btn_up  in  1  raw, asynchronous "channel up" button.
- btn_dn  in  1  raw, asynchronous "channel down" button.
- phase_inc  out  40  NCO phase increment (registered).
- pinc_valid  out  1  one-cycle strobe when phase_inc changes.
- chan  out  7  current channel index, 0..N_CH-1.
- mute  out  1  audio mute request.
- busy  out  1  high while not in IDLE.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high. All state changes on the CLK rising edge.
- Reset values: phase_inc=PINC_RESET, chan=CH_RESET, pinc_valid=0, mute=0, busy=0, FSM=IDLE, all counters 0.
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles.
  - Any bounce resets the debounce count.
- Step request:
  - Raised on a rising edge of a debounced level.
  - Auto-repeat: while a button stays debounced-high, further requests fire REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - Repeat counters clear on release.
- Both buttons debounced-high: no requests are generated and repeat counters are held at 0. A press while the other button is already held is ignored.
- Request arriving outside IDLE: dropped, not queued. Repeat timers keep running.
- FSM, IDLE -> STEP: on an up or down request.
- FSM, STEP (1 cycle):
  - Up, chan < N_CH-1: chan+1, phase_inc += PINC_STEP.
  - Up, chan = N_CH-1: wrap to chan=0, phase_inc -= (N_CH-1)*PINC_STEP.
  - Down mirrors up: at chan=0, wrap to N_CH-1 and add (N_CH-1)*PINC_STEP.
  - The wrap constant is computed at elaboration.
  - Next state: PUBLISH.
- FSM, PUBLISH (1 cycle): pinc_valid=1; mute=1; load the mute counter with MUTE_CYCLES-1. Next state: SETTLE.
- FSM, SETTLE: mute stays 1; the counter decrements to 0; then return to IDLE with mute=0.
- Latency: phase_inc changes 1 cycle after the request cycle. pinc_valid is high the cycle after phase_inc changes. mute goes low MUTE_CYCLES+1 cycles after pinc_valid.
- busy = (state != IDLE).
- Arithmetic: 40-bit modular arithmetic; no saturation. After any step sequence, phase_inc == PINC_RESET + (chan - CH_RESET)*PINC_STEP (mod 2^40).
- RST during any state: immediate return to the reset values above, including an in-progress mute.

Decomposition:
- Shared package `tune_pkg`:
  - FSM state enum {IDLE, STEP, PUBLISH, SETTLE}.
  - 9 kHz PINC_STEP constant.
  - Band limits.
  - Phase-width constant PINC_W=40, shared with the nco.
- One natural sub-module: `btn_debounce` (synchroniser + stable counter + rising-edge pulse + auto-repeat). Instantiated twice.

Test Plan (sim params: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, MUTE_CYCLES=10):
- Reset: assert RST for 3 cycles -> chan=45, phase_inc=40'h2656ABDE3, mute=0, pinc_valid=0, busy=0.
- Single up press, held for 6 cycles -> chan=46, phase_inc=40'h26B50B0F1, one pinc_valid pulse, then mute high for exactly 11 cycles.
- Bounce: btn_dn toggling every 2 cycles for 40 cycles, then low -> no change to chan, phase_inc or mute.
- Wrap: reset to chan 119 (CH_RESET=119), press up -> chan=0 and phase_inc = PINC_RESET - 119*PINC_STEP. Then press down -> chan=119 and phase_inc equals its original value.
- Auto-repeat: hold btn_up for 60 cycles after debounce -> steps at press+0, +20, +28, +36 …, each honoured only if busy=0. Check the phase_inc/chan invariant after each step.
- Both buttons: hold up, then press down, then press both together -> no step from the second press. RST asserted mid-SETTLE -> mute=0 next cycle, state=IDLE.
